seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed 4-digit common-anode 7-segment driver for the board top level.
//   Consumes the 16-bit CPU debug word (PCPU y) and drives the anode and segment pins.
//   Provides tear-free value update, leading-zero blanking, per-digit decimal points
//   and PWM brightness.
// PARAMETERS
//   SCAN_DIV  50_000  clock cycles per digit slot (1 ms at 50 MHz); legal range >= 8
//   BLANK_LZ  1       reset/default enable for leading-zero blanking, overridden by port
// PORTS
//   clock       in   1   system clock; all logic is rising-edge
//   reset_n     in   1   asynchronous, active-low reset
//   value       in   16  hex word to show; digit i = value[4i+3:4i]
//   load        in   1   capture value into the pending register this cycle
//   blank_lz    in   1   1 = suppress leading zero digits
//   dp_mask     in   4   1 = light decimal point of digit i
//   brightness  in   3   duty level: on-time = (brightness+1)/8 of each slot
//   an          out  4   anode enables, active-low, one-hot-low while lit
//   seg         out  7   segments a..g, active-low; seg[6]=a ... seg[0]=g
//   dp          out  1   decimal point, active-low
//   digit_tick  out  1   one-cycle pulse at the end of every digit slot
// BEHAVIOUR
//   Reset (async, immediate): an=4'b1111, seg=7'h7F, dp=1, digit_tick=0.
//     Prescaler=0, digit index=0, shadow=0, pending=0, pend_valid=0.
//   Prescaler: counts 0..SCAN_DIV-1 and wraps.
//     At SCAN_DIV-1: digit_tick=1 for that cycle; index <= index+1 mod 4.
//   Frame boundary: the cycle where the index wraps 3->0.
//   Load path:
//     load=1 sets pending<=value, pend_valid<=1; a later load overwrites (last wins).
//     At the frame boundary with pend_valid=1: shadow<=pending, pend_valid<=0.
//     load on the boundary cycle itself: shadow<=value directly, pend_valid stays 0.
//     Shadow never changes mid-frame, so a frame never mixes two values.
//   Display source is shadow only, never value.
//   Blanking: with blank_lz=1, digit i (i=1..3) is blanked when shadow nibbles
//     3..i are all zero. Digit 0 is never blanked; 0x0000 shows a single "0".
//     A blanked digit keeps an[i]=1, seg=7'h7F and dp=1.
//     dp_mask does not unblank a digit.
//   PWM:
//     on_cnt = ((brightness+1)*SCAN_DIV)>>3, computed at full width (no truncation
//       before the shift).
//     Digit lit while prescaler < on_cnt; otherwise an=4'b1111.
//     brightness=7 gives 100% duty.
//   Outputs are registered and reflect the index/prescaler state with exactly
//     1 cycle latency. an is never two-hot; at an index change the old anode drops
//     in the same cycle the new one rises.
//   Hex decode (a..g, active-low):
//     0=0000001  1=1001111  2=0010010  3=0000110
//     4=1001100  5=0100100  6=0100000  7=0001111
//     8=0000000  9=0000100  A=0001000  b=1100000
//     C=0110001  d=1000010  E=0110000  F=0111000
//   reset_n asserted mid-frame: all state cleared at once. After release, scanning
//     restarts at digit 0, prescaler 0, shadow 0.
// TESTING (bench SCAN_DIV=8)
//   1. Hold reset_n=0 -> an=1111, seg=7F, dp=1.
//      Release; load 16'h1234, brightness=7 -> next frame an walks 1110,1101,1011,0111
//      showing seg 1001100,0000110,0010010,1001111.
//   2. Tear-free: shadow=16'h1234, pulse load 16'hABCD while index=1 -> digits 1-3
//      keep 3,2,1; from the next digit 0 they show D,C,B,A.
//   3. Boundary load: load 16'h00F0 on the 3->0 wrap cycle, blank_lz=1 -> that same
//      frame shows digit0=0, digit1=F; an[3:2] stay 11.
//   4. value=0, blank_lz=1, dp_mask=4'b1111 -> only digit 0 lit (seg 0000001, dp=0).
//      Digits 1-3 stay dark with dp=1.
//   5. brightness=3 -> per slot an low for exactly 4 of 8 cycles.
//      brightness=0 -> low for exactly 1 of 8 cycles.
//   6. Assert reset_n=0 mid-slot at index 2 -> outputs go to reset values in the same
//      cycle. After release, digit_tick is first seen 8 cycles later and index=0.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
//   Bundles the display-facing signals of seg7_scan_driver.
//   master : board/CPU side; drives the value, load and display controls and
//            observes the pin outputs.
//   slave  : the scan driver itself.
//
//   value       16  hex word to show; digit i = value[4i+3:4i]
//   load         1  capture value into the pending register this cycle
//   blank_lz     1  1 = suppress leading zero digits
//   dp_mask      4  1 = light the decimal point of digit i
//   brightness   3  on-time = (brightness+1)/8 of each digit slot
//   an           4  anode enables, active-low
//   seg          7  segments a..g, active-low, seg[6]=a ... seg[0]=g
//   dp           1  decimal point, active-low
//   digit_tick   1  one-cycle pulse at the end of every digit slot
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [2:0]  brightness;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        digit_tick;

  modport master (
    output value, load, blank_lz, dp_mask, brightness,
    input  an, seg, dp, digit_tick
  );

  modport slave (
    input  value, load, blank_lz, dp_mask, brightness,
    output an, seg, dp, digit_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed 4-digit common-anode 7-segment driver. Shows the 16-bit
//   CPU debug word one hex digit at a time, with a tear-free update path
//   (pending -> shadow at frame boundaries only), leading-zero blanking,
//   per-digit decimal points and PWM brightness.
//
// Parameters
//   SCAN_DIV  clock cycles per digit slot (>= 8)
//   BLANK_LZ  reset value of the leading-zero blanking enable
//
// Ports
//   clock    in  system clock, rising edge
//   reset_n  in  asynchronous, active-low reset
//   bus      slave modport of seg7_scan_driver_if (value/load/controls in,
//            an/seg/dp/digit_tick out; all outputs registered)
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int SCAN_DIV = 50_000,
  parameter int BLANK_LZ = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic BLANK_RST = (BLANK_LZ != 0);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Hex nibble to active-low a..g pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every more significant nibble are
  // zero. Digit 0 is never blanked so an all-zero word still shows "0".
  function automatic logic is_leading_zero(input logic [15:0] word,
                                           input logic [1:0]  idx);
    logic z;
    case (idx)
      2'd1:    z = (word[15:4]  == 12'h000);
      2'd2:    z = (word[15:8]  == 8'h00);
      2'd3:    z = (word[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] a;
    case (idx)
      2'd0:    a = 4'b1110;
      2'd1:    a = 4'b1101;
      2'd2:    a = 4'b1011;
      default: a = 4'b0111;
    endcase
    return a;
  endfunction

  // PWM threshold: ((brightness+1)*SCAN_DIV)>>3, evaluated wide enough that
  // the product never truncates before the shift.
  function automatic logic [39:0] on_count(input logic [2:0] level);
    logic [39:0] prod;
    prod = (40'(level) + 40'd1) * 40'(SCAN_DIV);
    return prod >> 3;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q,      presc_d;
  logic [1:0]    idx_q,        idx_d;
  logic [15:0]   shadow_q,     shadow_d;
  logic [15:0]   pend_q,       pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic          blank_en_q,   blank_en_d;

  logic [3:0]    an_q,         an_d;
  logic [6:0]    seg_q,        seg_d;
  logic          dp_q,         dp_d;
  logic          tick_q,       tick_d;

  logic          slot_end;
  logic          frame_end;

  assign slot_end  = (presc_q == PW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_q == 2'd3);

  // ---------------------------------------------------------------------------
  // Scan counters and value update path
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d      = slot_end ? '0 : presc_q + PW'(1);
    idx_d        = slot_end ? idx_q + 2'd1 : idx_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    blank_en_d   = bus.blank_lz;

    if (frame_end) begin
      // Shadow only moves here, so one frame never mixes two words. A load
      // arriving on this very cycle bypasses pending and is the newest value.
      if (bus.load) begin
        shadow_d = bus.value;
      end else if (pend_valid_q) begin
        shadow_d = pend_q;
      end
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      pend_d       = bus.value;
      pend_valid_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered one cycle behind the scan state)
  // ---------------------------------------------------------------------------
  logic [3:0]  cur_nib;
  logic        cur_blank;
  logic        cur_pwm_on;
  logic        cur_lit;

  always_comb begin
    cur_nib    = shadow_q[{idx_q, 2'b00} +: 4];
    cur_blank  = blank_en_q && is_leading_zero(shadow_q, idx_q);
    cur_pwm_on = (40'(presc_q) < on_count(bus.brightness));
    cur_lit    = cur_pwm_on && !cur_blank;

    an_d   = 4'b1111;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    tick_d = slot_end;

    if (cur_lit) begin
      an_d  = anode_for(idx_q);
      seg_d = hex_to_seg(cur_nib);
      dp_d  = ~bus.dp_mask[idx_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      pend_q       <= 16'h0000;
      pend_valid_q <= 1'b0;
      blank_en_q   <= BLANK_RST;
      an_q         <= 4'b1111;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      blank_en_q   <= blank_en_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      tick_q       <= tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int DIV = 8;

  logic clock;
  logic reset_n;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(.SCAN_DIV(DIV), .BLANK_LZ(1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: n counts cycles since reset release; slot, digit and
  // frame are plain arithmetic on n.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    logic       segdp_defined;
  } exp_t;

  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  function automatic exp_t model_out(input int n, input logic [15:0] sh, input logic bl,
                                     input logic [3:0] mask, input logic [2:0] br);
    exp_t e;
    int p, i, on_cnt;
    bit blanked, lit;
    p       = n % DIV;
    i       = (n / DIV) % 4;
    on_cnt  = ((int'(br) + 1) * DIV) >> 3;
    blanked = bl && (i > 0) && ((sh >> (4 * i)) == 16'h0);
    lit     = (p < on_cnt) && !blanked;
    e.tick  = (p == DIV - 1);
    e.an    = lit ? ~(4'b0001 << i) : 4'b1111;
    e.seg   = lit ? HEX[sh[4*i +: 4]] : 7'h7F;
    e.dp    = lit ? ~mask[i] : 1'b1;
    e.segdp_defined = lit || blanked;
    return e;
  endfunction

  int          m_n;
  logic [15:0] m_shadow, m_pend;
  logic        m_pv, m_blank;
  exp_t        exp_o;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_n      <= 0;
      m_shadow <= 16'h0;
      m_pend   <= 16'h0;
      m_pv     <= 1'b0;
      m_blank  <= 1'b1;
      exp_o    <= '{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0, segdp_defined: 1'b1};
    end else begin
      exp_o   <= model_out(m_n, m_shadow, m_blank, bus.dp_mask, bus.brightness);
      m_blank <= bus.blank_lz;
      if ((m_n % (4 * DIV)) == 4 * DIV - 1) begin
        if (bus.load)  m_shadow <= bus.value;
        else if (m_pv) m_shadow <= m_pend;
        m_pv <= 1'b0;
      end else if (bus.load) begin
        m_pend <= bus.value;
        m_pv   <= 1'b1;
      end
      m_n <= m_n + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("an", {12'h0, bus.an}, {12'h0, exp_o.an});
      check("digit_tick", {15'h0, bus.digit_tick}, {15'h0, exp_o.tick});
      if (exp_o.segdp_defined) begin
        check("seg", {9'h0, bus.seg}, {9'h0, exp_o.seg});
        check("dp", {15'h0, bus.dp}, {15'h0, exp_o.dp});
      end
    end
  end

  // Wait for the falling edge at which the model cycle count equals target.
  // Outputs seen there belong to cycle target-1; inputs driven there are
  // sampled as cycle target.
  task automatic wait_m(input int target);
    int g;
    g = 0;
    do begin
      @(negedge clock);
      g++;
    end while (m_n != target && g < 4000);
    if (m_n != target) begin
      checks++;
      errors++;
      $display("FAIL wait_m: cycle count %0d never reached %0d", m_n, target);
    end
  endtask

  task automatic lit_check(input string name, input logic [3:0] an_e, input logic [6:0] seg_e);
    check({name, "_an"}, {12'h0, bus.an}, {12'h0, an_e});
    check({name, "_seg"}, {9'h0, bus.seg}, {9'h0, seg_e});
  endtask

  int cnt;
  int first_tick;

  initial begin
    reset_n        = 1'b1;
    bus.value      = 16'h0;
    bus.load       = 1'b0;
    bus.blank_lz   = 1'b0;
    bus.dp_mask    = 4'h0;
    bus.brightness = 3'd7;
    #1 reset_n = 1'b0;

    // 1. reset state and first frame of 0x1234
    repeat (3) @(negedge clock);
    check("rst_an", {12'h0, bus.an}, 16'h000F);
    check("rst_seg", {9'h0, bus.seg}, 16'h007F);
    check("rst_dp", {15'h0, bus.dp}, 16'h0001);
    check("rst_tick", {15'h0, bus.digit_tick}, 16'h0000);
    chk_en = 1'b1;
    reset_n   = 1'b1;
    bus.value = 16'h1234;
    bus.load  = 1'b1;
    wait_m(1);
    bus.load = 1'b0;

    wait_m(33);
    lit_check("t1_d0", 4'b1110, 7'b1001100);
    check("model_t1_seg", {9'h0, exp_o.seg}, {9'h0, 7'b1001100});
    // 2. load 0xABCD while digit 1 is being shown
    wait_m(40);
    bus.value = 16'hABCD;
    bus.load  = 1'b1;
    wait_m(41);
    lit_check("t1_d1", 4'b1101, 7'b0000110);
    bus.load  = 1'b0;
    bus.value = 16'h0000;
    wait_m(49);
    lit_check("t2_d2_old", 4'b1011, 7'b0010010);
    wait_m(57);
    lit_check("t2_d3_old", 4'b0111, 7'b1001111);
    wait_m(65);
    lit_check("t2_d0_new", 4'b1110, 7'b1000010);
    check("model_t2_seg", {9'h0, exp_o.seg}, {9'h0, 7'b1000010});
    wait_m(73);
    lit_check("t2_d1_new", 4'b1101, 7'b0110001);
    wait_m(81);
    lit_check("t2_d2_new", 4'b1011, 7'b1100000);
    wait_m(89);
    lit_check("t2_d3_new", 4'b0111, 7'b0001000);

    // 3. load on the frame-boundary cycle with blanking enabled
    wait_m(90);
    bus.blank_lz = 1'b1;
    wait_m(95);
    bus.value = 16'h00F0;
    bus.load  = 1'b1;
    wait_m(96);
    bus.load = 1'b0;
    wait_m(97);
    lit_check("t3_d0", 4'b1110, 7'b0000001);
    wait_m(105);
    lit_check("t3_d1", 4'b1101, 7'b0111000);
    wait_m(113);
    check("t3_d2_an", {12'h0, bus.an}, 16'h000F);
    check("model_t3_an", {12'h0, exp_o.an}, 16'h000F);
    wait_m(121);
    check("t3_d3_an", {12'h0, bus.an}, 16'h000F);

    // 4. all-zero word with all decimal points requested
    wait_m(128);
    bus.value   = 16'h0000;
    bus.load    = 1'b1;
    bus.dp_mask = 4'hF;
    wait_m(129);
    bus.load = 1'b0;
    wait_m(161);
    lit_check("t4_d0", 4'b1110, 7'b0000001);
    check("t4_d0_dp", {15'h0, bus.dp}, 16'h0000);
    for (int k = 1; k < 4; k++) begin
      wait_m(161 + k * DIV);
      lit_check("t4_dark", 4'b1111, 7'h7F);
      check("t4_dark_dp", {15'h0, bus.dp}, 16'h0001);
    end

    // 5. PWM duty at brightness 3 and 0 (digit 0 slots)
    wait_m(192);
    bus.brightness = 3'd3;
    cnt = 0;
    for (int k = 0; k < DIV; k++) begin
      wait_m(193 + k);
      if (bus.an != 4'b1111) cnt++;
    end
    check("t5_duty_b3", 16'(cnt), 16'd4);
    wait_m(224);
    bus.brightness = 3'd0;
    cnt = 0;
    for (int k = 0; k < DIV; k++) begin
      wait_m(225 + k);
      if (bus.an != 4'b1111) cnt++;
    end
    check("t5_duty_b0", 16'(cnt), 16'd1);

    // Randomised traffic, checked every cycle by the model.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clock);
      bus.load    = ($urandom_range(7) == 0);
      bus.value   = 16'($urandom) >> $urandom_range(15);
      bus.dp_mask = 4'($urandom);
      if ($urandom_range(63) == 0) bus.blank_lz = ~bus.blank_lz;
      if ($urandom_range(31) == 0) bus.brightness = 3'($urandom);
    end
    @(negedge clock);
    bus.load = 1'b0;

    // 6. reset in the middle of a digit-2 slot
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while ((m_n % (4 * DIV)) != 2 * DIV + 3 && cnt < 100);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_an", {12'h0, bus.an}, 16'h000F);
    check("t6_rst_seg", {9'h0, bus.seg}, 16'h007F);
    check("t6_rst_dp", {15'h0, bus.dp}, 16'h0001);
    check("t6_rst_tick", {15'h0, bus.digit_tick}, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    first_tick = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (c == 1) lit_check("t6_restart_d0", 4'b1110, 7'b0000001);
      if (bus.digit_tick && first_tick == 0) first_tick = c;
    end
    check("t6_first_tick", 16'(first_tick), 16'd8);

    repeat (40) @(negedge clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
